// File: rtl/traffic_timer.sv
// rtl/traffic_timer.sv - one-second-tick countdown timer for a traffic light controller
//
// Purpose:
//   Counts down a selected interval, in seconds, and pulses 'expired' for one
//   cycle when the interval has elapsed. There are three interval registers:
//   base, extended and yellow. Each resets to its parameter default.
//
// Optional feature:
//   TRAFFIC_TIMER_PROG_EN - when defined, a prog_sync strobe writes time_value
//   into the interval register that time_param_sel chooses. When undefined, the
//   interval registers hold their defaults and the programming inputs are unused.
//
// Ports:
//   clk            in   single clock, rising edge
//   g_reset        in   asynchronous active-low reset
//   start_timer    in   load the selected interval and start counting (any state)
//   interval[1:0]  in   00 base, 01 extended, 10 yellow, 11 base
//   prog_sync      in   one-cycle program strobe (synchronised upstream)
//   time_param_sel in   00 base, 01 extended, 10 yellow, 11 ignored
//   time_value[3:0] in  new interval value in seconds
//   expired        out  one-cycle pulse at end of countdown (registered)
//   running        out  high while a countdown is in progress (registered)

module traffic_timer #(
  parameter int CLK_PER_SEC = 4,
  parameter int BASE_DEF    = 6,
  parameter int EXT_DEF     = 3,
  parameter int YEL_DEF     = 2
) (
  input  logic       clk,
  input  logic       g_reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       prog_sync,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic       running
);

  localparam int              DIV_W    = $clog2(CLK_PER_SEC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_SEC - 1);
  localparam logic [3:0]      BASE_RST = 4'(BASE_DEF);
  localparam logic [3:0]      EXT_RST  = 4'(EXT_DEF);
  localparam logic [3:0]      YEL_RST  = 4'(YEL_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  state_e           state_q,   state_d;
  logic [3:0]       cnt_q,     cnt_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic             expired_q, expired_d;
  logic             running_q, running_d;
  logic [3:0]       base_q,    base_d;
  logic [3:0]       ext_q,     ext_d;
  logic [3:0]       yel_q,     yel_d;

  logic [3:0] sel_val;
  logic [3:0] load_val;
  logic       tick;

  // Interval selection always reads the current (pre-write) registers, so a
  // program strobe on the same edge as a start takes effect on the next start.
  always_comb begin
    sel_val = base_q;
    case (interval)
      2'b01:   sel_val = ext_q;
      2'b10:   sel_val = yel_q;
      default: sel_val = base_q;
    endcase
  end

  // A zero interval would never terminate cleanly; treat it as one second.
  assign load_val = (sel_val == 4'd0) ? 4'd1 : sel_val;

  assign tick = (state_q == COUNT) && (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    expired_d = 1'b0;

    if (start_timer) begin
      // Start wins over a coincident terminal tick: reload, no pulse.
      state_d = COUNT;
      cnt_d   = load_val;
      div_d   = '0;
    end else if (state_q == COUNT) begin
      if (tick) begin
        div_d = '0;
        if (cnt_q <= 4'd1) begin
          cnt_d     = 4'd0;
          state_d   = IDLE;
          expired_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    running_d = (state_d == COUNT);
  end

`ifdef TRAFFIC_TIMER_PROG_EN
  always_comb begin
    base_d = base_q;
    ext_d  = ext_q;
    yel_d  = yel_q;
    if (prog_sync) begin
      case (time_param_sel)
        2'b00:   base_d = time_value;
        2'b01:   ext_d  = time_value;
        2'b10:   yel_d  = time_value;
        default: ;
      endcase
    end
  end
`else
  always_comb begin
    base_d = base_q;
    ext_d  = ext_q;
    yel_d  = yel_q;
  end

  logic unused_prog;
  assign unused_prog = ^{prog_sync, time_param_sel, time_value};
`endif

  always_ff @(posedge clk or negedge g_reset) begin
    if (!g_reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      div_q     <= '0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
      base_q    <= BASE_RST;
      ext_q     <= EXT_RST;
      yel_q     <= YEL_RST;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      expired_q <= expired_d;
      running_q <= running_d;
      base_q    <= base_d;
      ext_q     <= ext_d;
      yel_q     <= yel_d;
    end
  end

  assign expired = expired_q;
  assign running = running_q;

endmodule

// File: doc/traffic_timer.md
TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 SHALL have parameter CLK_PER_SEC, default 4, meaning clock cycles per one-second tick (>=2).
REQ-002 SHALL have parameter BASE_DEF, default 6, meaning reset value of base interval in seconds.
REQ-003 SHALL have parameter EXT_DEF, default 3, meaning reset value of extended interval in seconds.
REQ-004 SHALL have parameter YEL_DEF, default 2, meaning reset value of yellow interval in seconds.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port g_reset  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start_timer  input  1  load and start countdown from selected interval.
REQ-008 SHALL have port interval  input  2  interval select: 00 base, 01 extended, 10 yellow, 11 base.
REQ-009 SHALL have port prog_sync  input  1  synchronised program strobe, one cycle.
REQ-010 SHALL have port time_param_sel  input  2  parameter to program: 00 base, 01 extended, 10 yellow, 11 ignored.
REQ-011 SHALL have port time_value  input  4  new interval value in seconds.
REQ-012 SHALL have port expired  output  1  one-cycle pulse at end of countdown.
REQ-013 SHALL have port running  output  1  high while a countdown is in progress.

Function
REQ-014 SHALL implement FSM states IDLE and COUNT; expired is a registered output, not a state.
REQ-015 SHALL, on a rising edge sampling start_timer=1, load the 4-bit counter with the selected interval register, clear the tick divider, and enter COUNT, from either state.
REQ-016 SHALL load 1 when the selected interval register holds 0.
REQ-017 SHALL, in COUNT, advance the divider every cycle and generate a tick when it reaches CLK_PER_SEC-1, then wrap it to 0.
REQ-018 SHALL decrement the counter on each tick; the tick that takes the counter from 1 to 0 returns the FSM to IDLE and sets expired for the following cycle only.
REQ-019 SHALL therefore assert expired exactly N*CLK_PER_SEC edges after the edge that sampled start_timer, where N is the loaded value.
REQ-020 SHALL give start_timer priority over a coincident terminal tick: reload, remain in COUNT, and suppress the expired pulse.
REQ-021 SHALL drive running=1 exactly while in COUNT.
REQ-022 SHALL, in IDLE, hold the counter and divider and never pulse expired.
REQ-023 SHALL leave a countdown in progress unchanged when its interval register is reprogrammed; the new value applies at the next start.

Reset
REQ-024 SHALL, while g_reset=0, immediately force: state IDLE, counter 0, divider 0, expired 0, running 0, base/ext/yellow registers to BASE_DEF/EXT_DEF/YEL_DEF.
REQ-025 SHALL abort any countdown on reset without emitting expired; the first start after reset release behaves per REQ-015.

Configuration
REQ-026 SHALL, when macro TRAFFIC_TIMER_PROG_EN is defined, write time_value into the register chosen by time_param_sel on any edge sampling prog_sync=1.
REQ-027 SHALL, when TRAFFIC_TIMER_PROG_EN is undefined, ignore prog_sync, time_param_sel and time_value, holding interval registers at their defaults.
REQ-028 SHALL give prog_sync and start_timer on the same edge this result: the register is written and the counter loads the old register value.

Verification (CLK_PER_SEC=4, defaults)
REQ-029 SHALL cover: reset release, start_timer with interval=00 -> running=1, expired single pulse 24 edges later, running=0 at that edge.
REQ-030 SHALL cover: interval=10 start -> expired after 8 edges; interval=11 -> after 24 edges.
REQ-031 SHALL cover: restart start_timer 10 edges into base countdown -> no expired at edge 24, expired at 34 from first start.
REQ-032 SHALL cover: with TRAFFIC_TIMER_PROG_EN, prog_sync sel=01 value=5 then extended start -> expired after 20 edges; sel=00 value=0 -> base expires after 4 edges; without macro the same stimulus gives 12 and 24 edges.
REQ-033 SHALL cover: g_reset low mid-countdown between edges -> expired and running 0 immediately, no later pulse; start_timer on terminal-tick edge -> no pulse, reload.
